// File: rtl/legv8_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : legv8_ctrl_pkg                                              |
// | Purpose : Shared encodings for the LEGv8 multi-cycle controller:      |
// |           FSM state codes, instruction classes, FS / data_tri /       |
// |           PC_FS control codes and opcode values.                      |
// | Ports   : none (package)                                              |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package legv8_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_HALT   = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      CLS_R    = 3'd0,
      CLS_I    = 3'd1,
      CLS_D    = 3'd2,
      CLS_B    = 3'd3,
      CLS_CB   = 3'd4,
      CLS_ZERO = 3'd5,
      CLS_ILL  = 3'd6
   } instr_class_t;

   // ALU function select
   localparam logic [4:0] c_fs_and = 5'b00000;
   localparam logic [4:0] c_fs_orr = 5'b01100;
   localparam logic [4:0] c_fs_add = 5'b01000;
   localparam logic [4:0] c_fs_sub = 5'b01001;

   // Data bus driver select
   localparam logic [1:0] c_dt_alu  = 2'b00;
   localparam logic [1:0] c_dt_regb = 2'b01;
   localparam logic [1:0] c_dt_pc   = 2'b10;
   localparam logic [1:0] c_dt_ram  = 2'b11;

   // PC function select
   localparam logic [1:0] c_pc_hold = 2'b00;
   localparam logic [1:0] c_pc_inc  = 2'b01;
   localparam logic [1:0] c_pc_addk = 2'b10;
   localparam logic [1:0] c_pc_bus  = 2'b11;

   localparam logic [4:0] c_xzr = 5'd31;

   // Opcodes, R and D formats use IR[31:21]
   localparam logic [10:0] c_op_add  = 11'b10001011000;
   localparam logic [10:0] c_op_sub  = 11'b11001011000;
   localparam logic [10:0] c_op_and  = 11'b10001010000;
   localparam logic [10:0] c_op_orr  = 11'b10101010000;
   localparam logic [10:0] c_op_ldur = 11'b11111000010;
   localparam logic [10:0] c_op_stur = 11'b11111000000;
   // I format uses IR[31:22]
   localparam logic [9:0]  c_op_addi = 10'b1001000100;
   localparam logic [9:0]  c_op_subi = 10'b1101000100;
   localparam logic [9:0]  c_op_andi = 10'b1001001000;
   localparam logic [9:0]  c_op_orri = 10'b1011001000;
   // B uses IR[31:26], CB uses IR[31:24]
   localparam logic [5:0]  c_op_b    = 6'b000101;
   localparam logic [7:0]  c_op_cbz  = 8'b10110100;
   localparam logic [7:0]  c_op_cbnz = 8'b10110101;

endpackage
`default_nettype wire

// File: rtl/legv8_instr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : legv8_instr_decode                                          |
// | Purpose : Combinational IR decode: instruction class, ALU function,   |
// |           register fields and the extended immediate k.               |
// | Ports   : i_ir      instruction register                              |
// |           o_cls     instruction class (R/I/D/B/CB/zero/illegal)       |
// |           o_fs,o_c0 ALU function and carry-in                         |
// |           o_is_load LDUR, o_is_cbz CBZ, o_sb_rt SB takes Rt           |
// |           o_rd/o_rn/o_rm/o_rt register fields, o_k immediate          |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module legv8_instr_decode
   import legv8_ctrl_pkg::*;
(
   input  logic [31:0]  i_ir,
   output instr_class_t o_cls,
   output logic [4:0]   o_fs,
   output logic         o_c0,
   output logic         o_is_load,
   output logic         o_is_cbz,
   output logic         o_sb_rt,
   output logic [4:0]   o_rd,
   output logic [4:0]   o_rn,
   output logic [4:0]   o_rm,
   output logic [4:0]   o_rt,
   output logic [31:0]  o_k
);

   assign o_rd = i_ir[4:0];
   assign o_rt = i_ir[4:0];
   assign o_rn = i_ir[9:5];
   assign o_rm = i_ir[20:16];

   always_comb begin
      o_cls     = CLS_ILL;
      o_fs      = c_fs_add;
      o_c0      = 1'b0;
      o_is_load = 1'b0;
      o_is_cbz  = 1'b0;
      o_sb_rt   = 1'b0;
      o_k       = '0;
      if (i_ir == 32'd0) begin
         o_cls = CLS_ZERO;
      end else begin
         case (i_ir[31:21])
            c_op_add:  begin o_cls = CLS_R; o_fs = c_fs_add; end
            c_op_sub:  begin o_cls = CLS_R; o_fs = c_fs_sub; o_c0 = 1'b1; end
            c_op_and:  begin o_cls = CLS_R; o_fs = c_fs_and; end
            c_op_orr:  begin o_cls = CLS_R; o_fs = c_fs_orr; end
            c_op_ldur: begin
               o_cls = CLS_D; o_is_load = 1'b1;
               o_k = {{23{i_ir[20]}}, i_ir[20:12]};
            end
            c_op_stur: begin
               o_cls = CLS_D; o_sb_rt = 1'b1;
               o_k = {{23{i_ir[20]}}, i_ir[20:12]};
            end
            default: ;
         endcase
         case (i_ir[31:22])
            c_op_addi: begin o_cls = CLS_I; o_fs = c_fs_add; o_k = {20'd0, i_ir[21:10]}; end
            c_op_subi: begin o_cls = CLS_I; o_fs = c_fs_sub; o_c0 = 1'b1; o_k = {20'd0, i_ir[21:10]}; end
            c_op_andi: begin o_cls = CLS_I; o_fs = c_fs_and; o_k = {20'd0, i_ir[21:10]}; end
            c_op_orri: begin o_cls = CLS_I; o_fs = c_fs_orr; o_k = {20'd0, i_ir[21:10]}; end
            default: ;
         endcase
         // Branch offsets are reduced by 4 because FETCH already advanced PC.
         if (i_ir[31:26] == c_op_b) begin
            o_cls = CLS_B;
            o_k   = {{4{i_ir[25]}}, i_ir[25:0], 2'b00} - 32'd4;
         end
         if ((i_ir[31:24] == c_op_cbz) || (i_ir[31:24] == c_op_cbnz)) begin
            o_cls    = CLS_CB;
            o_fs     = c_fs_orr;
            o_sb_rt  = 1'b1;
            o_is_cbz = (i_ir[31:24] == c_op_cbz);
            o_k      = {{11{i_ir[23]}}, i_ir[23:5], 2'b00} - 32'd4;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/legv8_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : legv8_multicycle_ctrl                                       |
// | Purpose : Multi-cycle FETCH/DECODE/EXEC/MEM/HALT sequencer driving    |
// |           every control input of dataPath_core.                       |
// | Ports   : clock, reset (async, active-high), start, IR_in, alu_zero,  |
// |           mem_ready (only with LEGV8_CTRL_MEMWAIT_EN);                |
// |           datapath controls w_reg C0 mem_cs mem_write_en IR_load      |
// |           status_load PC_sel B_Sel add_tri_sel FS PC_FS size          |
// |           data_tri_sel SA SB DA k; debug state_o halted illegal       |
// | Config  : LEGV8_CTRL_MEMWAIT_EN adds mem_ready; FETCH and MEM stall   |
// |           until it is high.                                           |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module legv8_multicycle_ctrl
   import legv8_ctrl_pkg::*;
#(
   parameter int RESET_HALT = 0
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] IR_in,
   input  logic        alu_zero,
`ifdef LEGV8_CTRL_MEMWAIT_EN
   input  logic        mem_ready,
`endif
   output logic        w_reg,
   output logic        C0,
   output logic        mem_cs,
   output logic        mem_write_en,
   output logic        IR_load,
   output logic        status_load,
   output logic        PC_sel,
   output logic        B_Sel,
   output logic        add_tri_sel,
   output logic [4:0]  FS,
   output logic [1:0]  PC_FS,
   output logic [1:0]  size,
   output logic [1:0]  data_tri_sel,
   output logic [4:0]  SA,
   output logic [4:0]  SB,
   output logic [4:0]  DA,
   output logic [31:0] k,
   output logic [2:0]  state_o,
   output logic        halted,
   output logic        illegal
);

   state_t       r_state, w_next;
   logic         r_illegal, w_set_illegal;
   logic         w_mem_ready;
   logic [1:0]   w_pc_fs_base;
   logic         w_cb_exec;

   instr_class_t w_cls;
   logic [4:0]   w_fs, w_rd, w_rn, w_rm, w_rt;
   logic         w_c0, w_is_load, w_is_cbz, w_sb_rt;
   logic [31:0]  w_k;

`ifdef LEGV8_CTRL_MEMWAIT_EN
   assign w_mem_ready = mem_ready;
`else
   assign w_mem_ready = 1'b1;
`endif

   legv8_instr_decode u_decode (
      .i_ir      (IR_in),
      .o_cls     (w_cls),
      .o_fs      (w_fs),
      .o_c0      (w_c0),
      .o_is_load (w_is_load),
      .o_is_cbz  (w_is_cbz),
      .o_sb_rt   (w_sb_rt),
      .o_rd      (w_rd),
      .o_rn      (w_rn),
      .o_rm      (w_rm),
      .o_rt      (w_rt),
      .o_k       (w_k)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= (RESET_HALT != 0) ? S_HALT : S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_set_illegal)
            r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_set_illegal = 1'b0;
      w_reg         = 1'b0;
      C0            = 1'b0;
      mem_cs        = 1'b1;
      mem_write_en  = 1'b0;
      IR_load       = 1'b0;
      status_load   = 1'b0;
      PC_sel        = 1'b0;
      B_Sel         = 1'b0;
      add_tri_sel   = 1'b0;
      FS            = '0;
      w_pc_fs_base  = c_pc_hold;
      size          = 2'b11;
      data_tri_sel  = c_dt_alu;
      SA            = '0;
      SB            = '0;
      DA            = '0;
      k             = '0;
      w_cb_exec     = 1'b0;
      case (r_state)
         S_FETCH: begin
            add_tri_sel  = 1'b0;
            data_tri_sel = c_dt_ram;
            IR_load      = 1'b1;
            // PC advances only on the edge that actually completes the fetch.
            if (w_mem_ready) begin
               w_pc_fs_base = c_pc_inc;
               w_next       = S_DECODE;
            end
         end
         S_DECODE: begin
            SA = w_rn;
            SB = w_sb_rt ? w_rt : w_rm;
            case (w_cls)
               CLS_ZERO: w_next = S_HALT;
               CLS_ILL:  begin w_set_illegal = 1'b1; w_next = S_HALT; end
               default:  w_next = S_EXEC;
            endcase
         end
         S_EXEC: begin
            w_next = S_FETCH;
            case (w_cls)
               CLS_R: begin
                  SA = w_rn; SB = w_rm; FS = w_fs; C0 = w_c0;
                  w_reg = 1'b1; DA = w_rd;
               end
               CLS_I: begin
                  SA = w_rn; FS = w_fs; C0 = w_c0; B_Sel = 1'b1; k = w_k;
                  w_reg = 1'b1; DA = w_rd;
               end
               CLS_D: begin
                  SA = w_rn; SB = w_sb_rt ? w_rt : w_rm; FS = c_fs_add;
                  B_Sel = 1'b1; k = w_k; add_tri_sel = 1'b1;
                  w_next = S_MEM;
               end
               CLS_B: begin
                  w_pc_fs_base = c_pc_addk; k = w_k;
               end
               CLS_CB: begin
                  // XZR | Rt through the ALU makes alu_zero report Rt == 0.
                  SA = c_xzr; SB = w_rt; FS = c_fs_orr; k = w_k;
                  w_cb_exec = 1'b1;
               end
               default: w_next = S_HALT;
            endcase
         end
         S_MEM: begin
            SA = w_rn; FS = c_fs_add; B_Sel = 1'b1; k = w_k; add_tri_sel = 1'b1;
            if (w_is_load) begin
               data_tri_sel = c_dt_ram; w_reg = 1'b1; DA = w_rt;
            end else begin
               data_tri_sel = c_dt_regb; SB = w_rt; mem_write_en = 1'b1;
            end
            if (w_mem_ready)
               w_next = S_FETCH;
         end
         S_HALT: begin
            if (start && !r_illegal)
               w_next = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Branch decision kept out of the main block so alu_zero only feeds PC_FS.
   assign PC_FS   = w_cb_exec ? ((alu_zero == w_is_cbz) ? c_pc_addk : c_pc_hold)
                              : w_pc_fs_base;
   assign state_o = r_state;
   assign halted  = (r_state == S_HALT);
   assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_legv8_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_legv8_multicycle_ctrl                                    |
// | Purpose : Self-checking bench; a small behavioural datapath (regfile, |
// |           PC, IR, instruction/data memory, ALU) runs a directed       |
// |           LEGv8 program under control of the DUT.                     |
// | Config  : LEGV8_CTRL_MEMWAIT_EN adds the fetch-stall scenario.        |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_legv8_multicycle_ctrl;

   logic        clock = 1'b0;
   logic        reset, start, alu_zero;
   logic [31:0] IR_in;
   logic        w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, PC_sel, B_Sel, add_tri_sel;
   logic [4:0]  FS, SA, SB, DA;
   logic [1:0]  PC_FS, size, data_tri_sel;
   logic [31:0] k;
   logic [2:0]  state_o;
   logic        halted, illegal;
`ifdef LEGV8_CTRL_MEMWAIT_EN
   logic        mem_ready;
`endif

   always #5 clock = ~clock;

   legv8_multicycle_ctrl dut (
      .clock(clock), .reset(reset), .start(start), .IR_in(IR_in), .alu_zero(alu_zero),
`ifdef LEGV8_CTRL_MEMWAIT_EN
      .mem_ready(mem_ready),
`endif
      .w_reg(w_reg), .C0(C0), .mem_cs(mem_cs), .mem_write_en(mem_write_en),
      .IR_load(IR_load), .status_load(status_load), .PC_sel(PC_sel), .B_Sel(B_Sel),
      .add_tri_sel(add_tri_sel), .FS(FS), .PC_FS(PC_FS), .size(size),
      .data_tri_sel(data_tri_sel), .SA(SA), .SB(SB), .DA(DA), .k(k),
      .state_o(state_o), .halted(halted), .illegal(illegal)
   );

   // ---------------- behavioural datapath ----------------
   logic [63:0] regs [0:31];
   logic [63:0] dmem [0:255];
   logic [31:0] imem [0:63];
   logic [63:0] pc, a_val, b_reg, b_val, alu, addr, bus, k64;

   always_comb begin
      k64   = {{32{k[31]}}, k};
      a_val = (SA == 5'd31) ? 64'd0 : regs[SA];
      b_reg = (SB == 5'd31) ? 64'd0 : regs[SB];
      b_val = B_Sel ? k64 : b_reg;
      case (FS)
         5'b00000: alu = a_val & b_val;
         5'b01100: alu = a_val | b_val;
         5'b01000: alu = a_val + b_val + {63'd0, C0};
         5'b01001: alu = a_val + ~b_val + {63'd0, C0};
         default:  alu = 64'd0;
      endcase
      alu_zero = (alu == 64'd0);
      addr = add_tri_sel ? alu : pc;
      case (data_tri_sel)
         2'b00:   bus = alu;
         2'b01:   bus = b_reg;
         2'b10:   bus = pc;
         default: bus = add_tri_sel ? dmem[addr[7:0]] : {32'd0, imem[pc[7:2]]};
      endcase
   end

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         pc    <= 64'd0;
         IR_in <= 32'd0;
      end else begin
         if (IR_load) IR_in <= bus[31:0];
         case (PC_FS)
            2'b01:   pc <= pc + 64'd4;
            2'b10:   pc <= pc + k64;
            2'b11:   pc <= bus;
            default: ;
         endcase
      end
   end

   always @(posedge clock) begin
      if (!reset) begin
         if (w_reg && DA != 5'd31) regs[DA] <= bus;
         if (mem_write_en) dmem[addr[7:0]] <= bus;
      end
   end

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] rtype(input logic [10:0] op, input logic [4:0] rm, rn, rd);
      return {op, rm, 6'd0, rn, rd};
   endfunction
   function automatic logic [31:0] itype(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rn, rd);
      return {op, imm, rn, rd};
   endfunction
   function automatic logic [31:0] dtype(input logic [10:0] op, input logic [8:0] imm, input logic [4:0] rn, rt);
      return {op, imm, 2'b00, rn, rt};
   endfunction
   function automatic logic [31:0] btype(input logic [25:0] imm);
      return {6'b000101, imm};
   endfunction
   function automatic logic [31:0] cbtype(input logic [7:0] op, input logic [18:0] imm, input logic [4:0] rt);
      return {op, imm, rt};
   endfunction

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int last_we_cnt, last_we_bad;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Steps one instruction from S_FETCH until the FSM is back in S_FETCH or halts.
   task automatic run_instr(input string tag, input int exp_cyc);
      int cyc = 0;
      int we_cnt = 0;
      int we_bad = 0;
      do begin
         @(posedge clock); cyc++;
         @(negedge clock);
         if (mem_write_en) begin
            we_cnt++;
            if (state_o != 3'd3) we_bad++;
         end
      end while (state_o != 3'd0 && state_o != 3'd7 && cyc < 20);
      check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
      last_we_cnt = we_cnt;
      last_we_bad = we_bad;
   endtask

   initial begin
      for (int i = 0; i < 32; i++)  regs[i] = 64'd0;
      for (int i = 0; i < 256; i++) dmem[i] = 64'd0;
      for (int i = 0; i < 64; i++)  imem[i] = 32'd0;
      regs[3] = 64'd7;
      imem[0]  = rtype(11'b10001011000, 5'd3, 5'd3, 5'd2);     // ADD  X2,X3,X3
      imem[1]  = itype(10'b1011001000, 12'd10, 5'd31, 5'd0);   // ORRI X0,XZR,#10
      imem[2]  = itype(10'b1001000100, 12'd5, 5'd0, 5'd1);     // ADDI X1,X0,#5
      imem[3]  = dtype(11'b11111000000, 9'd8, 5'd31, 5'd1);    // STUR X1,[X31,#8]
      imem[4]  = dtype(11'b11111000010, 9'd8, 5'd31, 5'd4);    // LDUR X4,[X31,#8]
      imem[5]  = rtype(11'b11001011000, 5'd0, 5'd1, 5'd5);     // SUB  X5,X1,X0
      imem[6]  = cbtype(8'b10110100, 19'd3, 5'd31);            // CBZ  X31,#3
      imem[7]  = itype(10'b1001000100, 12'd1, 5'd31, 5'd9);    // skipped
      imem[8]  = itype(10'b1001000100, 12'd1, 5'd31, 5'd9);    // skipped
      imem[9]  = cbtype(8'b10110101, 19'd3, 5'd31);            // CBNZ X31,#3
      imem[10] = cbtype(8'b10110100, 19'd2, 5'd0);             // CBZ  X0,#2
      imem[11] = btype(26'd2);                                 // B #2
      imem[12] = itype(10'b1001000100, 12'd1, 5'd31, 5'd9);    // skipped
      imem[13] = btype(26'd3);                                 // B #3
      imem[14] = cbtype(8'b10110101, 19'd3, 5'd0);             // CBNZ X0,#3
      imem[15] = itype(10'b1001000100, 12'd1, 5'd31, 5'd9);    // skipped
      imem[16] = btype(26'h3FFFFFE);                           // B #-2
      imem[17] = 32'd0;                                        // halt
      imem[18] = itype(10'b1001000100, 12'd7, 5'd31, 5'd10);   // ADDI X10,XZR,#7
      imem[19] = 32'hFFFF_FFFF;                                // illegal

      reset = 1'b1; start = 1'b0;
`ifdef LEGV8_CTRL_MEMWAIT_EN
      mem_ready = 1'b1;
`endif
      repeat (2) @(negedge clock);
      check("rst_state",   64'(state_o), 64'd0);
      check("rst_illegal", 64'(illegal), 64'd0);
      check("rst_wreg",    64'(w_reg),   64'd0);
      check("rst_memcs_size", 64'({mem_cs, size}), 64'b111);
      reset = 1'b0;

      // Abort ADD in the middle of S_EXEC.
      @(posedge clock); @(negedge clock);
      @(posedge clock); @(negedge clock);
      check("t1_exec_state", 64'(state_o), 64'd2);
      check("t1_exec_wreg",  64'(w_reg),   64'd1);
      reset = 1'b1; #1;
      check("t1_abort_state", 64'(state_o), 64'd0);
      check("t1_abort_wreg",  64'(w_reg),   64'd0);
      @(negedge clock); reset = 1'b0;
      check("t1_irload",  64'(IR_load), 64'd1);
      check("t1_illegal", 64'(illegal), 64'd0);
      check("t1_x2_unwritten", regs[2], 64'd0);

      run_instr("add", 3);
      check("add_x2", regs[2], 64'd14);
      check("add_pc", pc, 64'd4);
      run_instr("orri", 3);
      check("orri_x0", regs[0], 64'd10);
      check("orri_pc", pc, 64'd8);
      run_instr("addi", 3);
      check("addi_x1", regs[1], 64'd15);
      check("addi_pc", pc, 64'd12);
      run_instr("stur", 4);
      check("stur_ram8", dmem[8], 64'd15);
      check("stur_we_cnt", 64'(last_we_cnt), 64'd1);
      check("stur_we_outside_mem", 64'(last_we_bad), 64'd0);
      run_instr("ldur", 4);
      check("ldur_x4", regs[4], 64'd15);
      check("ldur_we_cnt", 64'(last_we_cnt), 64'd0);
      run_instr("sub", 3);
      check("sub_x5", regs[5], 64'd5);
      run_instr("cbz_taken", 3);
      check("cbz_taken_pc", pc, 64'd36);
      run_instr("cbnz_nt", 3);
      check("cbnz_nt_pc", pc, 64'd40);
      run_instr("cbz_nt", 3);
      check("cbz_nt_pc", pc, 64'd44);
      run_instr("b_fwd2", 3);
      check("b_fwd2_pc", pc, 64'd52);
      run_instr("b_fwd3", 3);
      check("b_fwd3_pc", pc, 64'd64);
      run_instr("b_back", 3);
      check("b_back_pc", pc, 64'd56);
      run_instr("cbnz_taken", 3);
      check("cbnz_taken_pc", pc, 64'd68);

      run_instr("halt", 2);
      check("halt_state",  64'(state_o), 64'd7);
      check("halt_halted", 64'(halted),  64'd1);
      check("halt_pc", pc, 64'd72);
      repeat (3) @(negedge clock);
      check("halt_pc_frozen", pc, 64'd72);
      check("halt_stays", 64'(state_o), 64'd7);
      start = 1'b1;
      @(negedge clock); start = 1'b0;
      check("start_to_fetch", 64'(state_o), 64'd0);
      run_instr("resume_addi", 3);
      check("resume_x10", regs[10], 64'd7);

      run_instr("illegal", 2);
      check("ill_flag",   64'(illegal), 64'd1);
      check("ill_halted", 64'(halted),  64'd1);
      start = 1'b1;
      repeat (2) @(negedge clock);
      start = 1'b0;
      check("ill_start_ignored", 64'(state_o), 64'd7);
      check("ill_sticky", 64'(illegal), 64'd1);
      check("skipped_x9", regs[9], 64'd0);

`ifdef LEGV8_CTRL_MEMWAIT_EN
      begin
         int ir_cnt = 0;
         reset = 1'b1; mem_ready = 1'b0;
         @(negedge clock); reset = 1'b0;
         check("mw_ill_cleared", 64'(illegal), 64'd0);
         for (int i = 0; i < 3; i++) begin
            if (IR_load) ir_cnt++;
            check("mw_pcfs_hold", 64'(PC_FS), 64'd0);
            @(posedge clock); @(negedge clock);
         end
         check("mw_pc_waiting", pc, 64'd0);
         check("mw_state_waiting", 64'(state_o), 64'd0);
         mem_ready = 1'b1;
         if (IR_load) ir_cnt++;
         @(posedge clock); @(negedge clock);
         check("mw_irload_cycles", 64'(ir_cnt), 64'd4);
         check("mw_pc_once", pc, 64'd4);
         check("mw_decode", 64'(state_o), 64'd1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
